dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the single-port data memory between two requesters:
//   - the core load/store port (c_*);
//   - a debug/loader port (d_*) used to preload or inspect memory.
// - Sequences each access through a fixed-latency memory.
// - Returns read data with a one-cycle ack pulse.
// - Drives core_stall, which gates the program counter update enable while a core access is outstanding.
// PARAMETERS
// - ADDR_W       default 10  word-address width of the memory
// - DATA_W       default 32  data width
// - WAIT_CYCLES  default 1   extra cycles mem_rdata needs after mem_en asserts (0..15)
// PORTS
// - clk          in   1       rising-edge clock
// - rst          in   1       reset, synchronous, active-high
// - c_req        in   1       core request; held with c_we/c_addr/c_wdata until c_ack
// - c_we         in   1       1=write, 0=read
// - c_addr       in   ADDR_W  core word address
// - c_wdata      in   DATA_W  core write data
// - c_ack        out  1       one-cycle completion pulse
// - c_rdata      out  DATA_W  read data, valid while c_ack=1
// - d_req/d_we/d_addr/d_wdata/d_ack/d_rdata   same as the c_* group, for the debug port
// - core_stall   out  1       c_req & ~c_ack (combinational)
// - mem_en       out  1       memory access enable
// - mem_we       out  1       memory write enable, qualified by mem_en
// - mem_addr     out  ADDR_W  memory address
// - mem_wdata    out  DATA_W  memory write data
// - mem_rdata    in   DATA_W  memory read data, valid WAIT_CYCLES cycles after mem_en rises
// BEHAVIOUR
// - Reset values:
//   - state=IDLE, last_grant=DEBUG, cnt=0, grant=CORE;
//   - all outputs 0, except core_stall, which follows c_req.
// - IDLE:
//   - Sample c_req/d_req.
//   - If only one is high, grant it.
//   - If both are high, grant the port that is not last_grant (round-robin). The core wins the first tie after reset.
//   - On grant: latch we/addr/wdata of the winner, set cnt=WAIT_CYCLES, update last_grant, go to ACCESS.
// - ACCESS:
//   - mem_en=1; mem_we/addr/wdata are driven from the latched values, stable for the whole state.
//   - While cnt!=0: cnt decrements.
//   - When cnt==0: register mem_rdata into the winner's rdata (writes also capture it; the value is don't-care), go to ACK.
// - ACK:
//   - mem_en=0; the winner's ack=1 for exactly one cycle; next state is IDLE.
//   - The losing port's ack stays 0.
//   - rdata holds its value until the next capture for that port.
// - Latency:
//   - Req sampled in IDLE at cycle T: mem_en is high in cycles T+1..T+1+WAIT_CYCLES; ack is high in cycle T+2+WAIT_CYCLES.
//   - Back-to-back throughput is one access per WAIT_CYCLES+3 cycles (IDLE is always visited for one cycle).
//   - Worst-case wait for a continuously requesting port is 2*(WAIT_CYCLES+3) cycles; no starvation.
// - Protocol:
//   - A requester may deassert req only in its ack cycle, or keep it high to issue a new access.
//   - A req dropped before ack is a violation. The arbiter still completes the access and pulses ack.
//   - Inputs of the granted port are not re-sampled after grant.
// - Writes: mem_we=1 with mem_en for the full ACCESS window. The memory commits on its own edge.
// - Reset mid-operation: the next cycle is IDLE, mem_en=0, and no ack is issued. A partially issued write may or may not have committed.
// - A request arriving during ACCESS/ACK is held off until IDLE; no queueing beyond the req level.
// TESTING
// 1. WAIT_CYCLES=1, core write addr=0x004 data=0xDEADBEEF, then read addr=0x004:
//    - mem_en high 2 cycles;
//    - c_ack at T+3;
//    - c_rdata=0xDEADBEEF;
//    - core_stall high from T until ack.
// 2. c_req and d_req rise in the same cycle after reset, both held:
//    - grant order is core, debug, core, debug;
//    - each ack is 4 cycles apart.
// 3. Only d_req held for 3 accesses (addr 0,1,2):
//    - d_ack every 4 cycles;
//    - c_ack stays 0;
//    - core_stall=0.
// 4. WAIT_CYCLES=0:
//    - read latency is 2 cycles from sampled req to ack;
//    - mem_en is a single-cycle pulse.
// 5. rst asserted during ACCESS of a core write:
//    - next cycle mem_en=0, c_ack=0, state IDLE;
//    - after release, a held c_req is granted normally.
// 6. Request with req dropped one cycle after grant:
//    - the access completes;
//    - a single ack pulse is issued;
//    - no second mem_en burst.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, fixed-latency data memory.
// Latency: req sampled in IDLE at T -> mem_en T+1..T+1+WAIT_CYCLES -> ack at T+2+WAIT_CYCLES.
// Backpressure: requesters hold req until their ack; core_stall = c_req & ~c_ack.
module dmem_port_arbiter #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_ack,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              core_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_ACK    = 2'd2
   } state_t;

   localparam logic       P_CORE  = 1'b0;
   localparam logic       P_DBG   = 1'b1;
   localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

   state_t              r_state;
   logic                r_last_grant;
   logic                r_grant;
   logic [3:0]          r_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_c_rdata;
   logic [DATA_W-1:0]   r_d_rdata;

   state_t              w_state_nxt;
   logic                w_grant_vld;
   logic                w_grant_dbg;
   logic                w_capture;
   logic                w_c_ack;
   logic                w_d_ack;

   // Next-state, round-robin grant decision and all control outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_vld = 1'b0;
      w_grant_dbg = 1'b0;
      w_capture   = 1'b0;
      w_c_ack     = 1'b0;
      w_d_ack     = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      case (r_state)
         S_IDLE: begin
            // On a tie the debug port wins only if the core had the last grant.
            w_grant_vld = c_req | d_req;
            w_grant_dbg = d_req & (~c_req | (r_last_grant == P_CORE));
            if (w_grant_vld) begin
               w_state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            mem_en = 1'b1;
            mem_we = r_we;
            if (r_cnt == 4'd0) begin
               w_capture   = 1'b1;
               w_state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            w_c_ack     = (r_grant == P_CORE);
            w_d_ack     = (r_grant == P_DBG);
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      c_ack      = w_c_ack;
      d_ack      = w_d_ack;
      core_stall = c_req & ~w_c_ack;
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign c_rdata   = r_c_rdata;
   assign d_rdata   = r_d_rdata;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Grant bookkeeping, latched request, wait counter and read-data capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= P_DBG;
         r_grant      <= P_CORE;
         r_cnt        <= 4'd0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_c_rdata    <= '0;
         r_d_rdata    <= '0;
      end else begin
         if (w_grant_vld) begin
            // The winner's request fields are frozen here and never re-sampled.
            r_grant      <= w_grant_dbg;
            r_last_grant <= w_grant_dbg;
            r_cnt        <= LP_WAIT;
            r_we         <= w_grant_dbg ? d_we    : c_we;
            r_addr       <= w_grant_dbg ? d_addr  : c_addr;
            r_wdata      <= w_grant_dbg ? d_wdata : c_wdata;
         end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_capture) begin
            if (r_grant == P_DBG) begin
               r_d_rdata <= mem_rdata;
            end else begin
               r_c_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule
